rgbd_vo_frame_ctrl: RTL and testbench

Configuration register file and frame sequencer for the RGB-D visual-odometry pipeline. It holds the programmable frame geometry, camera intrinsics and depth window (the `RgbdVoConfigPk` register map), and shadows them at frame start so the datapath sees stable values for a whole frame. It then generates the raster pixel-coordinate stream, with SOF/EOL/EOF markers, that paces the back-projection and cloud stages.

---
 rtl/rgbd_vo_frame_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_rgbd_vo_frame_ctrl.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgbd_vo_frame_ctrl.sv
// Configuration register file and raster frame sequencer for the RGB-D VO pipeline.
// Active registers are shadowed at frame start; the sequencer emits (x, y) beats with markers.
module rgbd_vo_frame_ctrl #(
    parameter int unsigned H_BW = 10,
    parameter int unsigned V_BW = 10,
    parameter int unsigned F_BW = 35,
    parameter int unsigned D_BW = 16
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_reg_we,
    input  logic            i_reg_re,
    input  logic [31:0]     i_reg_addr,
    input  logic [63:0]     i_reg_wdata,
    output logic [63:0]     o_reg_rdata,
    output logic            o_reg_rvalid,
    input  logic            i_frame_start,
    output logic            o_pix_valid,
    input  logic            i_pix_ready,
    output logic [H_BW-1:0] o_pix_x,
    output logic [V_BW-1:0] o_pix_y,
    output logic            o_sof,
    output logic            o_eol,
    output logic            o_eof,
    output logic [H_BW-1:0] o_h_size,
    output logic [V_BW-1:0] o_v_size,
    output logic [F_BW-1:0] o_fx,
    output logic [F_BW-1:0] o_fy,
    output logic [F_BW-1:0] o_cx,
    output logic [F_BW-1:0] o_cy,
    output logic [D_BW-1:0] o_depth_max,
    output logic [D_BW-1:0] o_depth_min,
    output logic            o_busy,
    output logic            o_frame_done,
    output logic            o_frame_abort,
    output logic            o_start_err
);

    localparam logic [31:0] ADDR_DISABLE = 32'd0;
    localparam logic [31:0] ADDR_H_SIZE  = 32'd1;
    localparam logic [31:0] ADDR_V_SIZE  = 32'd2;
    localparam logic [31:0] ADDR_FX      = 32'd3;
    localparam logic [31:0] ADDR_FY      = 32'd4;
    localparam logic [31:0] ADDR_CX      = 32'd5;
    localparam logic [31:0] ADDR_CY      = 32'd6;
    localparam logic [31:0] ADDR_DMAX    = 32'd7;
    localparam logic [31:0] ADDR_DMIN    = 32'd8;

    typedef enum logic [1:0] {st_idle, st_run, st_done} state_e;

    state_e          state_q;
    logic            dis_q;
    logic [H_BW-1:0] h_q;
    logic [V_BW-1:0] v_q;
    logic [F_BW-1:0] fx_q, fy_q, cx_q, cy_q;
    logic [D_BW-1:0] dmax_q, dmin_q;
    logic [63:0]     rd_val;
    logic [H_BW-1:0] x_q;
    logic [V_BW-1:0] y_q;
    logic            valid_q;
    logic            cfg_ok, abort_wr, accept, x_last, y_last;
    logic            unused_wdata;

    assign unused_wdata = ^i_reg_wdata[63:F_BW];

    // Active register file: writes land on the same edge regardless of sequencer state.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            dis_q  <= 1'b0;
            h_q    <= H_BW'(640);
            v_q    <= V_BW'(480);
            fx_q   <= '0;
            fy_q   <= '0;
            cx_q   <= '0;
            cy_q   <= '0;
            dmax_q <= {D_BW{1'b1}};
            dmin_q <= '0;
        end else if (i_reg_we) begin
            case (i_reg_addr)
                ADDR_DISABLE: dis_q  <= i_reg_wdata[0];
                ADDR_H_SIZE:  h_q    <= i_reg_wdata[H_BW-1:0];
                ADDR_V_SIZE:  v_q    <= i_reg_wdata[V_BW-1:0];
                ADDR_FX:      fx_q   <= i_reg_wdata[F_BW-1:0];
                ADDR_FY:      fy_q   <= i_reg_wdata[F_BW-1:0];
                ADDR_CX:      cx_q   <= i_reg_wdata[F_BW-1:0];
                ADDR_CY:      cy_q   <= i_reg_wdata[F_BW-1:0];
                ADDR_DMAX:    dmax_q <= i_reg_wdata[D_BW-1:0];
                ADDR_DMIN:    dmin_q <= i_reg_wdata[D_BW-1:0];
                default: ;
            endcase
        end
    end

    always_comb begin
        rd_val = '0;
        case (i_reg_addr)
            ADDR_DISABLE: rd_val = {63'd0, dis_q};
            ADDR_H_SIZE:  rd_val = 64'(h_q);
            ADDR_V_SIZE:  rd_val = 64'(v_q);
            ADDR_FX:      rd_val = {{(64-F_BW){fx_q[F_BW-1]}}, fx_q};
            ADDR_FY:      rd_val = {{(64-F_BW){fy_q[F_BW-1]}}, fy_q};
            ADDR_CX:      rd_val = {{(64-F_BW){cx_q[F_BW-1]}}, cx_q};
            ADDR_CY:      rd_val = {{(64-F_BW){cy_q[F_BW-1]}}, cy_q};
            ADDR_DMAX:    rd_val = 64'(dmax_q);
            ADDR_DMIN:    rd_val = 64'(dmin_q);
            default:      rd_val = '0;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_reg_rdata  <= '0;
            o_reg_rvalid <= 1'b0;
        end else begin
            o_reg_rvalid <= i_reg_re;
            if (i_reg_re) begin
                o_reg_rdata <= rd_val;
            end
        end
    end

    assign cfg_ok   = !dis_q && (h_q != '0) && (v_q != '0);
    assign abort_wr = i_reg_we && (i_reg_addr == ADDR_DISABLE) && i_reg_wdata[0];
    assign accept   = valid_q && i_pix_ready;
    assign x_last   = (x_q == o_h_size - H_BW'(1));
    assign y_last   = (y_q == o_v_size - V_BW'(1));

    // Sequencer; shadows load from pre-write active values because both sample the same edge.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q       <= st_idle;
            valid_q       <= 1'b0;
            x_q           <= '0;
            y_q           <= '0;
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
            o_start_err   <= 1'b0;
            o_h_size      <= H_BW'(640);
            o_v_size      <= V_BW'(480);
            o_fx          <= '0;
            o_fy          <= '0;
            o_cx          <= '0;
            o_cy          <= '0;
            o_depth_max   <= {D_BW{1'b1}};
            o_depth_min   <= '0;
        end else begin
            o_frame_done  <= 1'b0;
            o_frame_abort <= 1'b0;
            o_start_err   <= 1'b0;
            case (state_q)
                st_idle: begin
                    if (i_frame_start) begin
                        if (cfg_ok) begin
                            state_q     <= st_run;
                            valid_q     <= 1'b1;
                            x_q         <= '0;
                            y_q         <= '0;
                            o_h_size    <= h_q;
                            o_v_size    <= v_q;
                            o_fx        <= fx_q;
                            o_fy        <= fy_q;
                            o_cx        <= cx_q;
                            o_cy        <= cy_q;
                            o_depth_max <= dmax_q;
                            o_depth_min <= dmin_q;
                        end else begin
                            o_start_err <= 1'b1;
                        end
                    end
                end
                st_run: begin
                    o_start_err <= i_frame_start;
                    if (abort_wr) begin
                        state_q       <= st_idle;
                        valid_q       <= 1'b0;
                        o_frame_abort <= 1'b1;
                    end else if (accept) begin
                        if (x_last) begin
                            x_q <= '0;
                            if (y_last) begin
                                y_q          <= '0;
                                valid_q      <= 1'b0;
                                state_q      <= st_done;
                                o_frame_done <= 1'b1;
                            end else begin
                                y_q <= y_q + V_BW'(1);
                            end
                        end else begin
                            x_q <= x_q + H_BW'(1);
                        end
                    end
                end
                st_done: begin
                    o_start_err <= i_frame_start;
                    state_q     <= st_idle;
                end
                default: state_q <= st_idle;
            endcase
        end
    end

    assign o_pix_valid = valid_q;
    assign o_pix_x     = x_q;
    assign o_pix_y     = y_q;
    assign o_sof       = valid_q && (x_q == '0) && (y_q == '0);
    assign o_eol       = valid_q && x_last;
    assign o_eof       = valid_q && x_last && y_last;
    assign o_busy      = (state_q != st_idle);

endmodule

// File: tb/tb_rgbd_vo_frame_ctrl.sv
// Bench for rgbd_vo_frame_ctrl: register vector table, scoreboarded pixel stream and
// hand-written sequences for stalls, aborts, shadowing and error starts.
module tb_rgbd_vo_frame_ctrl;

    logic        clk = 1'b0;
    logic        i_rst_n, i_reg_we, i_reg_re, i_frame_start, i_pix_ready;
    logic [31:0] i_reg_addr;
    logic [63:0] i_reg_wdata, o_reg_rdata;
    logic        o_reg_rvalid, o_pix_valid, o_sof, o_eol, o_eof;
    logic [9:0]  o_pix_x, o_pix_y, o_h_size, o_v_size;
    logic [34:0] o_fx, o_fy, o_cx, o_cy;
    logic [15:0] o_depth_max, o_depth_min;
    logic        o_busy, o_frame_done, o_frame_abort, o_start_err;

    always #5 clk = ~clk;

    rgbd_vo_frame_ctrl dut (
        .i_clk(clk), .i_rst_n(i_rst_n),
        .i_reg_we(i_reg_we), .i_reg_re(i_reg_re), .i_reg_addr(i_reg_addr),
        .i_reg_wdata(i_reg_wdata), .o_reg_rdata(o_reg_rdata), .o_reg_rvalid(o_reg_rvalid),
        .i_frame_start(i_frame_start), .o_pix_valid(o_pix_valid), .i_pix_ready(i_pix_ready),
        .o_pix_x(o_pix_x), .o_pix_y(o_pix_y), .o_sof(o_sof), .o_eol(o_eol), .o_eof(o_eof),
        .o_h_size(o_h_size), .o_v_size(o_v_size), .o_fx(o_fx), .o_fy(o_fy),
        .o_cx(o_cx), .o_cy(o_cy), .o_depth_max(o_depth_max), .o_depth_min(o_depth_min),
        .o_busy(o_busy), .o_frame_done(o_frame_done), .o_frame_abort(o_frame_abort),
        .o_start_err(o_start_err)
    );

    typedef struct packed {
        logic        we;
        logic        re;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [63:0] exp_rd;
    } reg_vec_t;

    int          npass = 0;
    int          ntotal = 0;
    logic [63:0] sb_reg[$];
    logic [22:0] sb_pix[$];
    bit          hold_en = 1'b1;
    bit          stall_prev = 1'b0;
    logic [22:0] prev_beat;
    logic [22:0] cur_beat;
    reg_vec_t    vecs[24];

    assign cur_beat = {o_pix_x, o_pix_y, o_sof, o_eol, o_eof};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        ntotal++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %h, want %h", name, act, exp);
    endtask

    function automatic reg_vec_t mk(input logic we, input logic re, input logic [31:0] addr,
                                    input logic [63:0] wdata, input logic [63:0] exp_rd);
        mk = '{we: we, re: re, addr: addr, wdata: wdata, exp_rd: exp_rd};
    endfunction

    function automatic logic [22:0] beat_of(input int x, input int y, input int h, input int v);
        beat_of = {10'(x), 10'(y), (x == 0 && y == 0), (x == h - 1), (x == h - 1 && y == v - 1)};
    endfunction

    task automatic push_frame(input int h, input int v);
        for (int y = 0; y < v; y++)
            for (int x = 0; x < h; x++)
                sb_pix.push_back(beat_of(x, y, h, v));
    endtask

    always @(negedge clk) begin
        if (o_reg_rvalid) begin
            if (sb_reg.size() == 0) begin
                ntotal++;
                $display("FAIL rd_unexpected: got %h, want no read", o_reg_rdata);
            end else check("reg_read", o_reg_rdata, sb_reg.pop_front());
        end
        if (o_pix_valid && i_pix_ready) begin
            if (sb_pix.size() == 0) begin
                ntotal++;
                $display("FAIL pix_unexpected: got %h, want no beat", cur_beat);
            end else check("pix_beat", 64'(cur_beat), 64'(sb_pix.pop_front()));
        end
        if (hold_en && stall_prev)
            check("pix_hold", {40'd0, o_pix_valid, cur_beat}, {40'd0, 1'b1, prev_beat});
        stall_prev = o_pix_valid && !i_pix_ready;
        prev_beat  = cur_beat;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [31:0] addr, input logic [63:0] data);
        i_reg_we = 1'b1; i_reg_addr = addr; i_reg_wdata = data;
        tick();
        i_reg_we = 1'b0;
    endtask

    task automatic run_frame(input int h, input int v, input bit toggle, input bit fxw,
                             input logic [63:0] fxv, input logic [63:0] exp_fx, input bit sid);
        int cnt, acc, last_acc;
        push_frame(h, v);
        i_pix_ready = 1'b1;
        i_frame_start = 1'b1;
        i_reg_we = fxw; i_reg_addr = 32'd3; i_reg_wdata = fxv;
        tick();
        i_frame_start = 1'b0;
        i_reg_we = 1'b0;
        check("start_busy", o_busy, 1);
        check("start_sof", o_sof, 1);
        check("shadow_fx", o_fx, exp_fx);
        cnt = 1; acc = 0; last_acc = 0;
        while (!o_frame_done && cnt < 200) begin
            i_pix_ready = !toggle || (cnt % 2 == 1);
            if (o_pix_valid && i_pix_ready) begin
                acc++;
                last_acc = cnt;
            end
            tick();
            cnt++;
        end
        check("frame_timeout", cnt < 200, 1);
        check("accepts", acc, h * v);
        check("done_after_last", cnt, last_acc + 1);
        if (!toggle) check("done_latency", cnt, h * v + 1);
        check("done_busy", o_busy, 1);
        i_pix_ready = 1'b1;
        if (sid) i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("idle_busy", o_busy, 0);
        check("done_one_cycle", o_frame_done, 0);
        if (sid) check("start_err_done", o_start_err, 1);
        if (sid) check("no_beat_after_done", o_pix_valid, 0);
    endtask

    initial begin
        int done_seen;
        i_rst_n = 1'b0; i_reg_we = 1'b0; i_reg_re = 1'b0; i_reg_addr = '0; i_reg_wdata = '0;
        i_frame_start = 1'b0; i_pix_ready = 1'b1;
        repeat (3) tick();
        i_rst_n = 1'b1;
        check("rst_busy", o_busy, 0);
        check("rst_valid", o_pix_valid, 0);
        check("rst_rvalid", o_reg_rvalid, 0);
        check("rst_rdata", o_reg_rdata, 0);
        check("rst_h_size", o_h_size, 640);
        check("rst_v_size", o_v_size, 480);
        check("rst_fx", o_fx, 0);
        check("rst_depth_max", o_depth_max, 64'hFFFF);
        check("rst_pulses", {o_frame_done, o_frame_abort, o_start_err, o_sof}, 0);

        vecs[0]  = mk(0, 1, 0, 0, 0);
        vecs[1]  = mk(0, 1, 1, 0, 640);
        vecs[2]  = mk(0, 1, 2, 0, 480);
        vecs[3]  = mk(0, 1, 3, 0, 0);
        vecs[4]  = mk(0, 1, 4, 0, 0);
        vecs[5]  = mk(0, 1, 5, 0, 0);
        vecs[6]  = mk(0, 1, 6, 0, 0);
        vecs[7]  = mk(0, 1, 7, 0, 64'hFFFF);
        vecs[8]  = mk(0, 1, 8, 0, 0);
        vecs[9]  = mk(0, 1, 9, 0, 0);
        vecs[10] = mk(1, 0, 3, 64'hFFFF_FFFF_FFFF_FFFF, 0);
        vecs[11] = mk(0, 1, 3, 0, 64'hFFFF_FFFF_FFFF_FFFF);
        vecs[12] = mk(1, 0, 1, 64'h7FF, 0);
        vecs[13] = mk(0, 1, 1, 0, 64'h3FF);
        vecs[14] = mk(1, 1, 2, 64'd123, 480);
        vecs[15] = mk(0, 1, 2, 0, 123);
        vecs[16] = mk(1, 0, 9, 64'h55, 0);
        vecs[17] = mk(0, 1, 9, 0, 0);
        vecs[18] = mk(1, 0, 5, 64'hFFFF_FFFF_FFFF_FFFB, 0);
        vecs[19] = mk(0, 1, 5, 0, 64'hFFFF_FFFF_FFFF_FFFB);
        vecs[20] = mk(1, 0, 8, 64'hABCD, 0);
        vecs[21] = mk(0, 1, 8, 0, 64'hABCD);
        vecs[22] = mk(1, 0, 4, 64'hF000_0000_0000_1234, 0);
        vecs[23] = mk(0, 1, 4, 0, 64'h1234);
        for (int i = 0; i < 24; i++) begin
            i_reg_we = vecs[i].we; i_reg_re = vecs[i].re;
            i_reg_addr = vecs[i].addr; i_reg_wdata = vecs[i].wdata;
            if (vecs[i].re) sb_reg.push_back(vecs[i].exp_rd);
            tick();
        end
        i_reg_we = 1'b0; i_reg_re = 1'b0;
        repeat (2) tick();
        check("rd_drained", sb_reg.size(), 0);

        write_reg(3, 7);
        write_reg(1, 4);
        write_reg(2, 3);
        run_frame(4, 3, 0, 0, 0, 7, 1);
        run_frame(4, 3, 1, 0, 0, 7, 0);

        // Abort at beat 5 with ready low; FX written mid-frame must not reach o_fx.
        push_frame(4, 3);
        i_pix_ready = 1'b1;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        write_reg(3, 100);
        repeat (4) tick();
        check("fx_held_in_run", o_fx, 7);
        check("beat5_xy", {o_pix_x, o_pix_y}, {10'd1, 10'd1});
        hold_en = 1'b0;
        i_pix_ready = 1'b0;
        write_reg(0, 1);
        check("abort_valid", o_pix_valid, 0);
        check("abort_pulse", o_frame_abort, 1);
        check("abort_busy", o_busy, 0);
        done_seen = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (o_frame_done) done_seen++;
        end
        check("abort_no_done", done_seen, 0);
        check("abort_one_cycle", o_frame_abort, 0);
        check("abort_left_beats", sb_pix.size(), 7);
        sb_pix.delete();
        hold_en = 1'b1;
        i_pix_ready = 1'b1;
        write_reg(0, 0);

        run_frame(4, 3, 0, 1, 55, 100, 0);
        write_reg(1, 2);
        write_reg(2, 2);
        run_frame(2, 2, 0, 0, 0, 55, 0);

        write_reg(0, 1);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("err_disabled", o_start_err, 1);
        check("err_disabled_valid", o_pix_valid, 0);
        check("err_disabled_busy", o_busy, 0);
        tick();
        check("err_one_cycle", o_start_err, 0);
        write_reg(0, 0);
        write_reg(2, 0);
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("err_vzero", o_start_err, 1);
        check("err_vzero_valid", o_pix_valid, 0);
        write_reg(2, 3);

        i_pix_ready = 1'b0;
        i_frame_start = 1'b1;
        tick();
        i_frame_start = 1'b0;
        check("mid_busy", o_busy, 1);
        hold_en = 1'b0;
        i_rst_n = 1'b0;
        tick();
        i_rst_n = 1'b1;
        check("mid_rst_busy", o_busy, 0);
        check("mid_rst_valid", o_pix_valid, 0);
        check("mid_rst_h_size", o_h_size, 640);
        check("mid_rst_pulses", {o_frame_done, o_frame_abort, o_start_err}, 0);
        tick();
        hold_en = 1'b1;
        i_pix_ready = 1'b1;

        check("pix_queue_empty", sb_pix.size(), 0);
        check("reg_queue_empty", sb_reg.size(), 0);
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout, want finish");
        $fatal(1);
    end

endmodule
